// File: rtl/wb_port_arbiter_if.sv
// Write-back port bundle: ALU and load-return requests in, registered register-file write out.
// master = request side / register file, slave = the arbiter.
interface wb_port_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              alu_valid;
   logic [ADDR_W-1:0] alu_rd;
   logic [DATA_W-1:0] alu_data;
   logic              alu_ready;
   logic              mem_valid;
   logic [ADDR_W-1:0] mem_rd;
   logic [DATA_W-1:0] mem_data;
   logic              buf_full;
   logic              overflow;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;

   modport master (
      output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
      input  alu_ready, buf_full, overflow, rf_we, rf_waddr, rf_wdata
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
      output alu_ready, buf_full, overflow, rf_we, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: buffered in-order load returns take priority over ALU results.
// Define WB_ARB_FAIR_EN to bound how many load grants may pass a waiting ALU result.
module wb_port_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int DEPTH        = 4,
   parameter int MAX_LOAD_RUN = 4
) (
   input  logic             clk,
   input  logic             reset,
   wb_port_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0] ONE_CNT  = (PTR_W + 1)'(1);

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_buf_rd   [DEPTH];
   logic [DATA_W-1:0] r_buf_data [DEPTH];
   logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
   logic [PTR_W:0]    r_count, w_count_nxt;
   logic              r_buf_full, r_overflow;
   logic              r_rf_we;
   logic [ADDR_W-1:0] r_rf_waddr;
   logic [DATA_W-1:0] r_rf_wdata;

   logic              w_empty, w_override, w_pop, w_bypass, w_alu_grant;
   logic              w_push, w_drop, w_push_ok, w_grant;
   logic [ADDR_W-1:0] w_g_rd;
   logic [DATA_W-1:0] w_g_data;

   assign w_empty       = (r_state == IDLE);
   assign bus.alu_ready = w_override | (w_empty & ~bus.mem_valid);
   assign w_pop         = ~w_empty & ~w_override;
   assign w_bypass      = w_empty & bus.mem_valid & ~w_override;
   assign w_alu_grant   = bus.alu_valid & bus.alu_ready;
   // A load not taken this cycle goes to the tail; it is lost only if the tail has no room.
   assign w_push        = bus.mem_valid & ~w_bypass;
   assign w_drop        = w_push & (r_count == FULL_CNT) & ~w_pop;
   assign w_push_ok     = w_push & ~w_drop;

`ifdef WB_ARB_FAIR_EN
   localparam int RUN_W = $clog2(MAX_LOAD_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_LOAD_RUN);

   logic [RUN_W-1:0] r_run;

   assign w_override = bus.alu_valid & (r_run == RUN_MAX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                            r_run <= '0;
      else if (!bus.alu_valid || w_alu_grant) r_run <= '0;
      else if (w_pop || w_bypass)            r_run <= r_run + 1'b1;
   end
`else
   assign w_override = 1'b0;
`endif

   // NOTE: every variable gets a default before the priority chain, so no latch is inferred.
   always_comb begin
      w_grant  = 1'b1;
      w_g_rd   = bus.alu_rd;
      w_g_data = bus.alu_data;
      if (w_pop) begin
         w_g_rd   = r_buf_rd[r_rd_ptr];
         w_g_data = r_buf_data[r_rd_ptr];
      end else if (w_bypass) begin
         w_g_rd   = bus.mem_rd;
         w_g_data = bus.mem_data;
      end else if (!w_alu_grant) begin
         w_grant  = 1'b0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_push_ok) w_state_nxt = DRAIN;
         DRAIN:   if (w_pop && !w_push_ok && r_count == ONE_CNT) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push_ok, w_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_buf_full <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_count    <= w_count_nxt;
         r_buf_full <= (w_count_nxt == FULL_CNT);
         if (w_pop)     r_rd_ptr   <= r_rd_ptr + 1'b1;
         if (w_push_ok) r_wr_ptr   <= r_wr_ptr + 1'b1;
         if (w_drop)    r_overflow <= 1'b1;
      end
   end

   // NOTE: buffer storage has no reset; pointers and occupancy alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_buf_rd[r_wr_ptr]   <= bus.mem_rd;
         r_buf_data[r_wr_ptr] <= bus.mem_data;
      end
   end

   // Writes to x0 still consume the grant but never raise the enable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rf_we    <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
      end else begin
         r_rf_we <= w_grant & (w_g_rd != '0);
         if (w_grant) begin
            r_rf_waddr <= w_g_rd;
            r_rf_wdata <= w_g_data;
         end
      end
   end

   assign bus.buf_full = r_buf_full;
   assign bus.overflow = r_overflow;
   assign bus.rf_we    = r_rf_we;
   assign bus.rf_waddr = r_rf_waddr;
   assign bus.rf_wdata = r_rf_wdata;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random traffic against a
// queue-based reference model of the arbitration rules (fairness follows WB_ARB_FAIR_EN).
module tb_wb_port_arbiter;
   localparam int DATA_W       = 32;
   localparam int ADDR_W       = 5;
   localparam int DEPTH        = 4;
   localparam int MAX_LOAD_RUN = 4;
`ifdef WB_ARB_FAIR_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;

   wb_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   wb_port_arbiter #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_LOAD_RUN(MAX_LOAD_RUN)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } wr_t;

   // Reference model state
   wr_t               q[$];
   int                run;
   bit                m_ovf;
   logic              m_we;
   logic [ADDR_W-1:0] m_waddr;
   logic [DATA_W-1:0] m_wdata;
   bit                last_alu_g;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      run     = 0;
      m_ovf   = 1'b0;
      m_we    = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
   endtask

   task automatic check_outputs();
      check("rf_we",    32'(bus.rf_we),    32'(m_we));
      check("rf_waddr", 32'(bus.rf_waddr), 32'(m_waddr));
      check("rf_wdata", 32'(bus.rf_wdata), 32'(m_wdata));
      check("buf_full", 32'(bus.buf_full), 32'(q.size() == DEPTH));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
   endtask

   task automatic drive(input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] adata,
                        input logic mv, input logic [ADDR_W-1:0] mrd, input logic [DATA_W-1:0] mdata);
      bus.alu_valid = av;
      bus.alu_rd    = ard;
      bus.alu_data  = adata;
      bus.mem_valid = mv;
      bus.mem_rd    = mrd;
      bus.mem_data  = mdata;
   endtask

   // One clock: check the combinational ready, advance the model, check registered outputs.
   task automatic step();
      bit  ovr, exp_ready, grant, alu_g, mem_taken;
      wr_t w;
      #1;
      ovr       = FAIR && bus.alu_valid && (run == MAX_LOAD_RUN);
      exp_ready = ovr || (q.size() == 0 && !bus.mem_valid);
      check("alu_ready", 32'(bus.alu_ready), 32'(exp_ready));
      grant = 1'b1; alu_g = 1'b0; mem_taken = 1'b0;
      w = '{rd: bus.alu_rd, data: bus.alu_data};
      if (ovr)                  alu_g = 1'b1;
      else if (q.size() != 0)   w = q.pop_front();
      else if (bus.mem_valid) begin
         w = '{rd: bus.mem_rd, data: bus.mem_data};
         mem_taken = 1'b1;
      end
      else if (bus.alu_valid)   alu_g = 1'b1;
      else                      grant = 1'b0;
      if (bus.mem_valid && !mem_taken) begin
         if (q.size() < DEPTH) q.push_back('{rd: bus.mem_rd, data: bus.mem_data});
         else                  m_ovf = 1'b1;
      end
      if (!bus.alu_valid || alu_g) run = 0;
      else if (grant)              run++;
      m_we = grant && (w.rd != '0);
      if (grant) begin
         m_waddr = w.rd;
         m_wdata = w.data;
      end
      last_alu_g = alu_g;
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      reset = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk);
      #1;
      check_outputs();
      reset = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      int first_alu;
      int pct;
      reset = 1'b0;
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      model_reset();
      last_alu_g = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      reset = 1'b1;

      // ALU only
      drive(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, '0, '0); step();
      drive(1'b0, '0, '0, 1'b0, '0, '0);             step();

      // Collision: load first, ALU held one cycle
      drive(1'b1, 5'd6, 32'h22, 1'b1, 5'd5, 32'h11); step();
      drive(1'b1, 5'd6, 32'h22, 1'b0, '0, '0);       step();
      drive(1'b0, '0, '0, 1'b0, '0, '0);             step();

      // x0 suppression
      drive(1'b1, 5'd0, 32'h55, 1'b0, '0, '0);       step();
      drive(1'b0, '0, '0, 1'b0, '0, '0);             step();

      // Five back-to-back loads with a waiting ALU result
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, 5'd7, 32'h77, 1'b1, ADDR_W'(i), 32'h100 + 32'(i));
         step();
      end
      for (int i = 0; i < 4; i++) begin
         drive(!last_alu_g && bus.alu_valid, 5'd7, 32'h77, 1'b0, '0, '0);
         step();
      end

      // Fairness: ALU granted on the 5th grant cycle only when the limit is built in
      do_reset();
      first_alu = -1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 5'd9, 32'h99, 1'b1, ADDR_W'(i + 1), $urandom);
         step();
         if (last_alu_g && first_alu < 0) first_alu = i;
      end
      check("fair_first_alu", 32'(first_alu), FAIR ? 32'd4 : 32'hFFFF_FFFF);

      // Reset in the middle of a drain, then confirm nothing stale is written
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 5'd10, 32'hA0, 1'b1, ADDR_W'(i + 1), $urandom);
         step();
      end
      do_reset();
      for (int i = 0; i < 6; i++) step();

      // Sustained loads with a waiting ALU: fills the buffer and overflows when fairness steals slots
      for (int i = 0; i < 30; i++) begin
         drive(1'b1, 5'd11, 32'hB0, 1'b1, ADDR_W'($urandom_range(1, 31)), $urandom);
         step();
      end
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      for (int i = 0; i < 6; i++) step();
      do_reset();

      // Random traffic; ALU fields are held until the handshake completes
      for (int i = 0; i < 1500; i++) begin
         pct = (i < 500) ? 30 : (i < 1000) ? 70 : 95;
         if (!bus.alu_valid || last_alu_g) begin
            bus.alu_valid = ($urandom_range(0, 3) != 0);
            bus.alu_rd    = ADDR_W'($urandom);
            bus.alu_data  = $urandom;
         end
         bus.mem_valid = ($urandom_range(0, 99) < pct);
         bus.mem_rd    = ADDR_W'($urandom);
         bus.mem_data  = $urandom;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
